// File: rtl/jeff_74x191.sv
`default_nettype none
// ============================================================================
// Module   : jeff_74x191
// Purpose  : Presettable binary up/down counter with max/min and ripple clock
// Revision : 1.0
// ============================================================================
module jeff_74x191 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             ld,
    input  logic             cten,
    input  logic             d_u,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic             max_min,
    output logic             rco
);

    localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_q;
    logic             w_max_min;

    // Load outranks counting; count direction only matters when enabled.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_q <= '0;
        end else if (!ld) begin
            r_q <= din;
        end else if (!cten) begin
            r_q <= d_u ? (r_q - c_one) : (r_q + c_one);
        end
    end

    // Terminal value depends on direction: zero when counting down, all-ones up.
    always_comb begin
        w_max_min = d_u ? (r_q == '0) : (&r_q);
    end

    assign q       = r_q;
    assign max_min = w_max_min;
    // Low only during clk-low of the cycle whose next rising edge wraps.
    assign rco     = ~(w_max_min & ~cten & ~clk);

endmodule
`default_nettype wire

// File: tb/tb_jeff_74x191.sv
`default_nettype none
// ============================================================================
// Module   : tb_jeff_74x191
// Purpose  : Scoreboard bench for jeff_74x191, single stage and 8-bit cascades
// Revision : 1.0
// ============================================================================
module tb_jeff_74x191;

    logic       clk;
    logic       clr;
    logic       ld;
    logic       cten;
    logic       d_u;
    logic [3:0] din;
    logic [7:0] din8;

    logic [3:0] q;
    logic       mm;
    logic       rco;

    logic [3:0] rq0, rq1, sq0, sq1;
    logic       rmm0, rmm1, smm0, smm1;
    logic       rrco0, rrco1, srco0, srco1;
    logic       rclk1;
    logic       scten1;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] sb[$];

    jeff_74x191 #(.WIDTH(4)) dut (
        .clk(clk), .clr(clr), .ld(ld), .cten(cten), .d_u(d_u),
        .din(din), .q(q), .max_min(mm), .rco(rco)
    );

    // Ripple pair: upper stage clocked by lower rco; loads use the system clock
    // because load is synchronous.
    assign rclk1 = ld ? rrco0 : clk;

    jeff_74x191 #(.WIDTH(4)) r0 (
        .clk(clk), .clr(clr), .ld(ld), .cten(cten), .d_u(d_u),
        .din(din8[3:0]), .q(rq0), .max_min(rmm0), .rco(rrco0)
    );
    jeff_74x191 #(.WIDTH(4)) r1 (
        .clk(rclk1), .clr(clr), .ld(ld), .cten(cten), .d_u(d_u),
        .din(din8[7:4]), .q(rq1), .max_min(rmm1), .rco(rrco1)
    );

    // Synchronous pair: upper stage enabled by lower max_min.
    assign scten1 = cten | ~smm0;

    jeff_74x191 #(.WIDTH(4)) s0 (
        .clk(clk), .clr(clr), .ld(ld), .cten(cten), .d_u(d_u),
        .din(din8[3:0]), .q(sq0), .max_min(smm0), .rco(srco0)
    );
    jeff_74x191 #(.WIDTH(4)) s1 (
        .clk(clk), .clr(clr), .ld(ld), .cten(scten1), .d_u(d_u),
        .din(din8[7:4]), .q(sq1), .max_min(smm1), .rco(srco1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset;
        logic [7:0] exp;
        clr = 1'b0; ld = 1'b1; cten = 1'b1; d_u = 1'b0; din = 4'd0; din8 = 8'h00;
        #1;
        n_checks++; if (q !== 4'd0) begin n_errors++; $display("FAIL reset_q got=%0d want=0", q); end
        n_checks++; if (mm !== 1'b0) begin n_errors++; $display("FAIL reset_mm got=%b want=0", mm); end
        n_checks++; if (rco !== 1'b1) begin n_errors++; $display("FAIL reset_rco got=%b want=1", rco); end
        @(posedge clk); #1;
        clr = 1'b1; ld = 1'b0; din = 4'd9;
        sb.push_back(8'd9);
        @(posedge clk); #1;
        exp = sb.pop_front();
        n_checks++; if (q !== exp[3:0]) begin n_errors++; $display("FAIL reset_load9 got=%0d want=%0d", q, exp); end
        ld = 1'b0; ld = 1'b1; cten = 1'b0; d_u = 1'b1;
        #2; clr = 1'b0; #1;
        n_checks++; if (q !== 4'd0) begin n_errors++; $display("FAIL clr_mid_q got=%0d want=0", q); end
        n_checks++; if (mm !== 1'b1) begin n_errors++; $display("FAIL clr_mid_mm got=%b want=1", mm); end
        n_checks++; if (rco !== 1'b1) begin n_errors++; $display("FAIL clr_mid_rco_high got=%b want=1", rco); end
        @(negedge clk); #1;
        n_checks++; if (rco !== 1'b0) begin n_errors++; $display("FAIL clr_mid_rco_low got=%b want=0", rco); end
        clr = 1'b1;
        sb.push_back(8'd15);
        @(posedge clk); #1;
        exp = sb.pop_front();
        n_checks++; if (q !== exp[3:0]) begin n_errors++; $display("FAIL clr_release_count got=%0d want=%0d", q, exp); end
    endtask

    task automatic test_up_wrap;
        logic [7:0] exp;
        logic [3:0] cur;
        ld = 1'b0; din = 4'd0; cten = 1'b0; d_u = 1'b0;
        sb.push_back(8'd0);
        @(posedge clk); #1;
        exp = sb.pop_front();
        n_checks++; if (q !== exp[3:0]) begin n_errors++; $display("FAIL up_load0 got=%0d want=%0d", q, exp); end
        ld = 1'b1;
        cur = 4'd0;
        for (int i = 1; i <= 17; i++) sb.push_back(8'(i % 16));
        for (int i = 0; i < 17; i++) begin
            n_checks++; if (mm !== (cur == 4'd15)) begin n_errors++; $display("FAIL up_mm q=%0d got=%b want=%b", cur, mm, (cur == 4'd15)); end
            n_checks++; if (rco !== 1'b1) begin n_errors++; $display("FAIL up_rco_clkhigh q=%0d got=%b want=1", cur, rco); end
            @(negedge clk); #1;
            n_checks++; if (rco !== (cur != 4'd15)) begin n_errors++; $display("FAIL up_rco_clklow q=%0d got=%b want=%b", cur, rco, (cur != 4'd15)); end
            @(posedge clk); #1;
            exp = sb.pop_front();
            n_checks++; if (q !== exp[3:0]) begin n_errors++; $display("FAIL up_count step=%0d got=%0d want=%0d", i, q, exp); end
            cur = exp[3:0];
        end
    endtask

    task automatic test_down_wrap;
        logic [7:0] exp;
        logic [3:0] cur;
        ld = 1'b0; din = 4'd3; cten = 1'b0; d_u = 1'b0;
        sb.push_back(8'd3);
        @(posedge clk); #1;
        exp = sb.pop_front();
        n_checks++; if (q !== exp[3:0]) begin n_errors++; $display("FAIL down_load3 got=%0d want=%0d", q, exp); end
        ld = 1'b1; d_u = 1'b1;
        cur = 4'd3;
        sb.push_back(8'd2); sb.push_back(8'd1); sb.push_back(8'd0);
        sb.push_back(8'd15); sb.push_back(8'd14);
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++; if (mm !== (cur == 4'd0)) begin n_errors++; $display("FAIL down_mm q=%0d got=%b want=%b", cur, mm, (cur == 4'd0)); end
            @(posedge clk); #1;
            exp = sb.pop_front();
            n_checks++; if (q !== exp[3:0]) begin n_errors++; $display("FAIL down_count step=%0d got=%0d want=%0d", i, q, exp); end
            cur = exp[3:0];
        end
    endtask

    task automatic test_priority_hold;
        logic [7:0] exp;
        ld = 1'b0; cten = 1'b0; din = 4'd10; d_u = 1'b0;
        sb.push_back(8'd10);
        @(posedge clk); #1;
        exp = sb.pop_front();
        n_checks++; if (q !== exp[3:0]) begin n_errors++; $display("FAIL prio_load got=%0d want=%0d", q, exp); end
        ld = 1'b1; cten = 1'b1;
        for (int i = 0; i < 4; i++) sb.push_back(8'd10);
        for (int i = 0; i < 4; i++) begin
            d_u = i[0]; #1;
            n_checks++; if (mm !== 1'b0) begin n_errors++; $display("FAIL hold10_mm got=%b want=0", mm); end
            @(posedge clk); #1;
            exp = sb.pop_front();
            n_checks++; if (q !== exp[3:0]) begin n_errors++; $display("FAIL hold10_q got=%0d want=%0d", q, exp); end
        end
        // Hold at zero: max_min follows direction, rco stays high while disabled.
        ld = 1'b0; din = 4'd0; d_u = 1'b1;
        sb.push_back(8'd0);
        @(posedge clk); #1;
        exp = sb.pop_front();
        n_checks++; if (q !== exp[3:0]) begin n_errors++; $display("FAIL load0_q got=%0d want=%0d", q, exp); end
        ld = 1'b1;
        for (int i = 0; i < 4; i++) sb.push_back(8'd0);
        for (int i = 0; i < 4; i++) begin
            d_u = i[0]; #1;
            n_checks++; if (mm !== (i % 2 == 1)) begin n_errors++; $display("FAIL hold0_mm d_u=%b got=%b want=%b", d_u, mm, (i % 2 == 1)); end
            @(negedge clk); #1;
            n_checks++; if (rco !== 1'b1) begin n_errors++; $display("FAIL hold0_rco got=%b want=1", rco); end
            @(posedge clk); #1;
            exp = sb.pop_front();
            n_checks++; if (q !== exp[3:0]) begin n_errors++; $display("FAIL hold0_q got=%0d want=%0d", q, exp); end
        end
    endtask

    task automatic test_dir_flip;
        logic [7:0] exp;
        ld = 1'b0; din = 4'd15; d_u = 1'b0; cten = 1'b1;
        sb.push_back(8'd15);
        @(posedge clk); #1;
        exp = sb.pop_front();
        n_checks++; if (q !== exp[3:0]) begin n_errors++; $display("FAIL flip_load got=%0d want=%0d", q, exp); end
        n_checks++; if (mm !== 1'b1) begin n_errors++; $display("FAIL flip_mm_up got=%b want=1", mm); end
        d_u = 1'b1; #1;
        n_checks++; if (mm !== 1'b0) begin n_errors++; $display("FAIL flip_mm_down got=%b want=0", mm); end
        ld = 1'b1; cten = 1'b0;
        sb.push_back(8'd14);
        @(posedge clk); #1;
        exp = sb.pop_front();
        n_checks++; if (q !== exp[3:0]) begin n_errors++; $display("FAIL flip_count got=%0d want=%0d", q, exp); end
    endtask

    task automatic test_cascade;
        logic [7:0] exp;
        logic       exp_mm1;
        for (int dir = 0; dir < 2; dir++) begin
            ld = 1'b0; cten = 1'b0;
            if (dir == 0) begin
                d_u = 1'b1; din8 = 8'h01;
                sb.push_back(8'h01); sb.push_back(8'h00); sb.push_back(8'hFF); sb.push_back(8'hFE);
            end else begin
                d_u = 1'b0; din8 = 8'hFE;
                sb.push_back(8'hFE); sb.push_back(8'hFF); sb.push_back(8'h00); sb.push_back(8'h01);
            end
            for (int k = 0; k < 4; k++) begin
                @(posedge clk); #1;
                exp = sb.pop_front();
                exp_mm1 = d_u ? (exp[7:4] == 4'h0) : (exp[7:4] == 4'hF);
                n_checks++; if ({rq1, rq0} !== exp) begin n_errors++; $display("FAIL ripple dir=%0d step=%0d got=%h want=%h", dir, k, {rq1, rq0}, exp); end
                n_checks++; if ({sq1, sq0} !== exp) begin n_errors++; $display("FAIL sync dir=%0d step=%0d got=%h want=%h", dir, k, {sq1, sq0}, exp); end
                n_checks++; if ({rmm1, smm1} !== {exp_mm1, exp_mm1}) begin n_errors++; $display("FAIL cascade_mm_hi dir=%0d step=%0d got=%b%b want=%b", dir, k, rmm1, smm1, exp_mm1); end
                n_checks++; if ({rrco1, srco1, srco0} !== 3'b111) begin n_errors++; $display("FAIL cascade_rco_clkhigh got=%b%b%b want=111", rrco1, srco1, srco0); end
                if (k == 0) ld = 1'b1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_priority_hold();
        test_dir_flip();
        test_cascade();
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
